// File: rtl/xor_tester_pkg.sv
// Shared types and helpers for the XOR cell self-test sequencer.
package xor_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned ERR_W   = 8;

  // Expected cell output for vector index v: A = v[1], B = v[0].
  function automatic logic exp_out(input logic [1:0] v);
    return v[1] ^ v[0];
  endfunction

endpackage

// File: rtl/xor_tester_settle_cnt.sv
// Loadable settle down-counter; expired marks the final settle cycle.
module xor_tester_settle_cnt #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  // Load on entry to SETTLE, count down while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(SETTLE_CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd1);

endmodule

// File: rtl/xor_cell_tester.sv
// Self-test sequencer for the XOR cell: sweeps all four input vectors,
// settles, samples and scores the cell output.
// Optional macro XOR_TESTER_STOP_ON_FAIL_EN: end the run at the first mismatch.
module xor_cell_tester
  import xor_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SWEEPS        = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dut_out,
  output logic               dut_a,
  output logic               dut_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [NUM_VEC-1:0] fail_vec
);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] sweep;
  logic       expired;
  logic       mismatch;
  logic       stop_hit;
  logic       last_vec;
  logic       last_sweep;
  logic [1:0] next_idx;
  logic [ERR_W-1:0] err_inc;

  xor_tester_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (state == APPLY),
    .en     (state == SETTLE),
    .expired(expired)
  );

  // Sample scoring and sweep bookkeeping.
  always_comb begin
    mismatch   = (dut_out != exp_out(idx));
    last_vec   = (idx == 2'(NUM_VEC - 1));
    last_sweep = (sweep == 8'(SWEEPS - 1));
    next_idx   = idx + 2'd1;
    err_inc    = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
`ifdef XOR_TESTER_STOP_ON_FAIL_EN
    stop_hit   = mismatch;
`else
    stop_hit   = 1'b0;
`endif
  end

  // Sequencer FSM with registered drive, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      sweep    <= '0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= APPLY;
            idx      <= '0;
            sweep    <= '0;
            dut_a    <= 1'b0;
            dut_b    <= 1'b0;
            busy     <= 1'b1;
            err_cnt  <= '0;
            fail_vec <= '0;
          end
        end
        APPLY: state <= SETTLE;
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_cnt       <= err_inc;
            fail_vec[idx] <= 1'b1;
          end
          // pass folds in this final sample since err_cnt updates on the same edge.
          if (stop_hit || (last_vec && last_sweep)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            if (last_vec) sweep <= sweep + 8'd1;
            idx   <= next_idx;
            dut_a <= next_idx[1];
            dut_b <= next_idx[0];
            state <= APPLY;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_cell_tester.sv
// Directed bench for xor_cell_tester (default and SWEEPS=3 instances).
module tb_xor_cell_tester;

`ifdef XOR_TESTER_STOP_ON_FAIL_EN
  localparam int S0_DONE = 13, S0_ERR = 1, S0_FV = 2;
  localparam int S1_DONE = 7,  S1_ERR = 1, S1_FV = 1;
  localparam int RST_MODE = 0, RST_ERR10 = 0;
`else
  localparam int S0_DONE = 25, S0_ERR = 2, S0_FV = 6;
  localparam int S1_DONE = 73, S1_ERR = 6, S1_FV = 9;
  localparam int RST_MODE = 2, RST_ERR10 = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [1:0] mode0;  // 0 ideal XOR, 1 stuck at 0, 2 stuck at 1
  logic       dut_out0, dut_out1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err0, err1;
  logic [3:0] fv0, fv1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int d1, d2;
  bit saw;

  always #5 clk = ~clk;

  assign dut_out0 = (mode0 == 2'd0) ? (a0 ^ b0) : (mode0 == 2'd2);
  assign dut_out1 = 1'b1;

  xor_cell_tester #(.SETTLE_CYCLES(4), .SWEEPS(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dut_out0),
    .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0)
  );

  xor_cell_tester #(.SETTLE_CYCLES(4), .SWEEPS(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(dut_out1),
    .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start is high during cycle 0; APPLY of vector 0 is cycle 1.
  task automatic begin_run(input int which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    cyc = 1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input bit probe, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 2000; k++) begin
      if (probe) begin
        if (cyc == 1)  begin check("busy_c1", busy0, 1); check("ab_c1", {a0, b0}, 0); end
        if (cyc == 7)  check("ab_c7", {a0, b0}, 1);
        if (cyc == 13) check("ab_c13", {a0, b0}, 2);
        if (cyc == 19) check("ab_c19", {a0, b0}, 3);
      end
      if ((which == 0) ? done0 : done1) begin
        dcyc = cyc;
        return;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 2'd0;
    repeat (3) tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_fv", fv0, 0);
    check("rst_ab", {a0, b0}, 0);
    rst = 1'b0;
    tick();

    // Ideal cell, defaults.
    mode0 = 2'd0;
    begin_run(0);
    wait_done(0, 1'b1, d1);
    check("ideal_done_cyc", d1, 25);
    check("ideal_pass", pass0, 1);
    check("ideal_err", err0, 0);
    check("ideal_fv", fv0, 0);
    check("ideal_busy_done", busy0, 0);
    tick();
    check("ideal_done_pulse", done0, 0);
    check("ideal_ab_hold", {a0, b0}, 3);
    check("ideal_pass_hold", pass0, 1);
    repeat (2) tick();

    // Reset mid-run, then a clean run started at cycle 15.
    mode0 = RST_MODE[1:0];
    begin_run(0);
    while (cyc < 10) tick();
    check("rst_mid_err10", err0, RST_ERR10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_err", err0, 0);
    check("rst_mid_pass", pass0, 0);
    check("rst_mid_ab", {a0, b0}, 0);
    saw = 1'b0;
    while (cyc < 15) begin
      saw |= done0;
      tick();
    end
    saw |= done0;
    check("rst_mid_no_done", saw, 0);
    mode0 = 2'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(0, 1'b0, d1);
    check("rst_restart_done_cyc", d1, 40);
    check("rst_restart_pass", pass0, 1);
    repeat (2) tick();

    // Cell output stuck at 0.
    mode0 = 2'd1;
    begin_run(0);
    wait_done(0, 1'b0, d1);
    check("s0_done_cyc", d1, S0_DONE);
    check("s0_err", err0, S0_ERR);
    check("s0_fv", fv0, S0_FV);
    check("s0_pass", pass0, 0);
    repeat (2) tick();

    // Start held high: second run starts the IDLE cycle after DONE.
    mode0 = 2'd1;
    start0 = 1'b1;
    tick();
    cyc = 1;
    wait_done(0, 1'b0, d1);
    check("held_done1_cyc", d1, S0_DONE);
    tick();
    check("held_idle_busy", busy0, 0);
    check("held_idle_done", done0, 0);
    check("held_idle_err", err0, S0_ERR);
    mode0 = 2'd0;
    tick();
    start0 = 1'b0;
    check("held_apply_busy", busy0, 1);
    check("held_apply_err", err0, 0);
    check("held_apply_fv", fv0, 0);
    wait_done(0, 1'b0, d2);
    check("held_done2_cyc", d2, S0_DONE + 26);
    check("held_pass2", pass0, 1);
    repeat (2) tick();

    // SWEEPS=3 instance, cell output stuck at 1.
    begin_run(1);
    wait_done(1, 1'b0, d1);
    check("s1_done_cyc", d1, S1_DONE);
    check("s1_err", err1, S1_ERR);
    check("s1_fv", fv1, S1_FV);
    check("s1_pass", pass1, 0);
    check("s1_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_cell_tester.md
# xor_cell_tester

Self-test sequencer for the transistor-level XOR cell. On a start pulse it drives the cell's two inputs through all four input combinations, for a configurable number of sweeps. It waits a settle interval after each change, samples the cell output and compares it with the expected XOR. It reports a pass/fail flag, a saturating error count and a per-vector failure map. It sits between the lab control logic and the XOR cell instance, and replaces the free-running clock stimulus used in standalone cell simulation.

## Interface
- SETTLE_CYCLES, 4: cycles held after applying a vector before sampling; legal range 1..255
- SWEEPS, 1: full 4-vector sweeps per run; legal range 1..255
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- dut_out  in  1  XOR cell output
- dut_a  out  1  drive to cell input A
- dut_b  out  1  drive to cell input B
- busy  out  1  high from APPLY of the first vector through the last SAMPLE
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  result of the last completed run; 1 means zero mismatches
- err_cnt  out  8  mismatch count of the current/last run, saturates at 255
- fail_vec  out  4  bit i set if vector i mismatched in any sweep

## Operation
- Vector index i is a 2-bit value; dut_b = i[0] and dut_a = i[1], so B toggles fastest. Order: 00, 01, 10, 11.
- Expected output is dut_a ^ dut_b.
- States and transitions:
  - IDLE: on start=1, go to APPLY. This clears err_cnt and fail_vec, sets the vector index to 0 and the sweep count to 0.
  - APPLY: registered dut_a/dut_b already hold vector i. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: compare dut_out with the expected value. On mismatch, increment err_cnt (saturating) and set fail_vec[i].
    - If i < 3: increment i and go to APPLY.
    - If i = 3 and this is not the last sweep: increment the sweep count, set i to 0, go to APPLY.
    - Otherwise go to DONE.
  - DONE: done=1 for one cycle. pass is updated to (err_cnt == 0) including this run's final sample. Go to IDLE.
- Output behaviour outside a run:
  - dut_a/dut_b hold the last applied vector after a run.
  - pass, err_cnt and fail_vec hold until the next start is accepted.
- start is ignored while not in IDLE, including the DONE cycle.
- Reset values: state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
- Reset mid-run: the run is aborted at the next edge with all reset values. No done pulse is produced.

## Timing
- start accepted at edge 0; APPLY of vector 0 in cycle 1.
- Each vector occupies SETTLE_CYCLES+2 cycles (APPLY, SETTLE, SAMPLE).
- done is asserted in cycle 1 + 4·SWEEPS·(SETTLE_CYCLES+2). For the defaults this is cycle 25.
- dut_out is sampled on the edge ending the SAMPLE cycle. Error updates are visible on the following cycle.
- busy falls in the DONE cycle.

## Configuration
- XOR_TESTER_STOP_ON_FAIL_EN:
  - Defined: the first mismatch in SAMPLE goes directly to DONE. err_cnt ends at 1, fail_vec has exactly one bit set, and pass=0.
  - Undefined: every vector of every sweep is applied regardless of mismatches.

## Structure
- Package xor_tester_pkg holds:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE)
  - NUM_VEC = 4
  - ERR_W = 8
  - expected-output function of the 2-bit vector index
- Sub-module xor_tester_settle_cnt: a loadable down-counter. It is loaded with SETTLE_CYCLES on entry to SETTLE and flags expiry. The sequencer owns everything else.

## Test plan
- Ideal XOR model on dut_out, defaults, start at cycle 0 → done pulse at cycle 25, pass=1, err_cnt=0, fail_vec=4'b0000.
- dut_out stuck at 0 → err_cnt=2, fail_vec=4'b0110, pass=0.
- SWEEPS=3, dut_out stuck at 1 → err_cnt=6, fail_vec=4'b1001, done at cycle 73.
- rst asserted at cycle 10 of a run → the next cycle shows IDLE, busy=0, err_cnt=0 and no done pulse. A start at cycle 15 then completes normally at cycle 40.
- start held high throughout the run → only one run occurs. A second start, accepted in the IDLE cycle after DONE, begins a new run with err_cnt and fail_vec cleared.
- XOR_TESTER_STOP_ON_FAIL_EN defined, dut_out stuck at 1 → done at cycle 7, err_cnt=1, fail_vec=4'b0001, pass=0.
